// File: rtl/measure_scheduler.sv
// Ranging sequencer: periodic meas_start, timed wait for meas_done, near/far
// hysteresis for presence, object count (binary + BCD) and LCD req/ack update.
module measure_scheduler #(
  parameter int unsigned PERIOD_CYCLES  = 3_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
  parameter int unsigned NEAR_CM        = 10,
  parameter int unsigned FAR_CM         = 15,
  parameter int unsigned CONFIRM_N      = 3,
  parameter int unsigned COUNT_MAX      = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        meas_start,
  input  logic        meas_done,
  input  logic [15:0] distancia_cm,
  output logic        present,
  output logic [6:0]  count,
  output logic [7:0]  count_bcd,
  output logic        lcd_req,
  input  logic        lcd_ack,
  output logic [7:0]  err_cnt
);
  localparam int unsigned PW = (PERIOD_CYCLES  > 1) ? $clog2(PERIOD_CYCLES)  : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   NEAR_V    = 16'(NEAR_CM);
  localparam logic [15:0]   FAR_V     = 16'(FAR_CM);
  localparam logic [3:0]    CONF_LAST = 4'(CONFIRM_N - 1);
  localparam logic [6:0]    CMAX      = 7'(COUNT_MAX);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_EVAL, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] per_q, per_d;
  logic [TW-1:0] wait_q, wait_d;
  logic [15:0]   dist_q, dist_d;
  logic          tmo_q, tmo_d;
  logic [3:0]    near_q, near_d, far_q, far_d;
  logic          present_q, present_d;
  logic [6:0]    count_q, count_d;
  logic [7:0]    bcd_q, bcd_d;
  logic          pend_q, pend_d;
  logic          req_q, req_d;
  logic [7:0]    err_q, err_d;
  logic          is_near, is_far, pend_set, req_rise;

  // A timed-out sample carries no valid distance and always counts as far.
  assign is_near = !tmo_q && (dist_q != 16'd0) && (dist_q < NEAR_V);
  assign is_far  = tmo_q || (dist_q == 16'd0) || (dist_q >= FAR_V);

  always_comb begin
    state_d   = state_q;
    per_d     = (per_q == PER_LAST) ? '0 : per_q + PW'(1);
    wait_d    = wait_q;
    dist_d    = dist_q;
    tmo_d     = tmo_q;
    near_d    = near_q;
    far_d     = far_q;
    present_d = present_q;
    count_d   = count_q;
    bcd_d     = bcd_q;
    err_d     = err_q;
    pend_set  = 1'b0;

    case (state_q)
      S_IDLE: begin
        per_d = '0;
        if (enable) state_d = S_START;
      end
      S_START: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q + TW'(1);
        if (meas_done) begin
          dist_d  = distancia_cm;
          tmo_d   = 1'b0;
          state_d = S_EVAL;
        end else if (wait_q == TMO_LAST) begin
          dist_d  = '0;
          tmo_d   = 1'b1;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        state_d = S_HOLD;
        if (!present_q) begin
          if (!is_near) begin
            near_d = '0;
          end else if (near_q == CONF_LAST) begin
            present_d = 1'b1;
            near_d    = '0;
            pend_set  = 1'b1;
            if (count_q == CMAX) begin
              count_d = '0;
              bcd_d   = '0;
            end else begin
              count_d = count_q + 7'd1;
              if (bcd_q[3:0] == 4'd9) bcd_d = {bcd_q[7:4] + 4'd1, 4'd0};
              else                    bcd_d = {bcd_q[7:4], bcd_q[3:0] + 4'd1};
            end
          end else begin
            near_d = near_q + 4'd1;
          end
        end else begin
          if (!is_far) begin
            far_d = '0;
          end else if (far_q == CONF_LAST) begin
            present_d = 1'b0;
            far_d     = '0;
          end else begin
            far_d = far_q + 4'd1;
          end
        end
      end
      S_HOLD: begin
        if (per_q == PER_LAST) state_d = enable ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Increments during an open request only re-arm pending; the LCD reads the live count.
  always_comb begin
    req_rise = !req_q && !lcd_ack && pend_q;
    req_d    = req_q;
    if (req_rise)               req_d = 1'b1;
    else if (req_q && lcd_ack)  req_d = 1'b0;
    pend_d = pend_set | (pend_q & ~req_rise);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      per_q     <= '0;
      wait_q    <= '0;
      dist_q    <= '0;
      tmo_q     <= 1'b0;
      near_q    <= '0;
      far_q     <= '0;
      present_q <= 1'b0;
      count_q   <= '0;
      bcd_q     <= '0;
      pend_q    <= 1'b0;
      req_q     <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      wait_q    <= wait_d;
      dist_q    <= dist_d;
      tmo_q     <= tmo_d;
      near_q    <= near_d;
      far_q     <= far_d;
      present_q <= present_d;
      count_q   <= count_d;
      bcd_q     <= bcd_d;
      pend_q    <= pend_d;
      req_q     <= req_d;
      err_q     <= err_d;
    end
  end

  assign meas_start = (state_q == S_START);
  assign present    = present_q;
  assign count      = count_q;
  assign count_bcd  = bcd_q;
  assign lcd_req    = req_q;
  assign err_cnt    = err_q;
endmodule

// File: tb/tb_measure_scheduler.sv
// Scoreboard bench for measure_scheduler: a sensor responder feeds queued samples
// and predicts outcomes; separate monitors compare at each result and LCD request.
module tb_measure_scheduler;
  localparam int PER = 100, TMO = 40, NEAR = 10, FAR = 15, CONF = 3, CMAX = 99;

  logic        clk, rst, enable, meas_start, meas_done, present, lcd_req, lcd_ack;
  logic [15:0] distancia_cm;
  logic [6:0]  count;
  logic [7:0]  count_bcd, err_cnt;

  typedef struct {bit done; int dly; int d;} samp_t;
  typedef struct {bit pres; int cnt; int err;} exp_t;

  samp_t samp_q[$];
  exp_t  exp_q[$];
  int    lcd_q[$];
  int    n_chk = 0, n_fail = 0, cyc = 0, n_start = 0, last_done = -100;
  bit    m_pres = 0;
  int    m_nr = 0, m_fr = 0, m_cnt = 0, m_err = 0;

  measure_scheduler #(
    .PERIOD_CYCLES(PER), .TIMEOUT_CYCLES(TMO), .NEAR_CM(NEAR), .FAR_CM(FAR),
    .CONFIRM_N(CONF), .COUNT_MAX(CMAX)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .meas_start(meas_start),
    .meas_done(meas_done), .distancia_cm(distancia_cm), .present(present),
    .count(count), .count_bcd(count_bcd), .lcd_req(lcd_req), .lcd_ack(lcd_ack),
    .err_cnt(err_cnt)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic push(input int d, input int dly = 5, input bit done = 1'b1);
    samp_t s;
    s.done = done; s.dly = dly; s.d = d;
    samp_q.push_back(s);
  endtask

  task automatic wait_samp(input int budget);
    int n = 0;
    while (samp_q.size() != 0 && n < budget) begin @(posedge clk); #2; n++; end
    if (samp_q.size() != 0) fail_now("wait_samp_timeout");
  endtask

  task automatic wait_exp(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); #2; n++; end
    if (exp_q.size() != 0) fail_now("wait_exp_timeout");
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_meas_start"}, int'(meas_start), 0);
    check({tag, "_present"},    int'(present),    0);
    check({tag, "_count"},      int'(count),      0);
    check({tag, "_count_bcd"},  int'(count_bcd),  0);
    check({tag, "_lcd_req"},    int'(lcd_req),    0);
    check({tag, "_err_cnt"},    int'(err_cnt),    0);
  endtask

  // Ultrasonic responder + reference model of presence/count/errors.
  initial begin : responder
    samp_t s;
    exp_t  e;
    bit    to, nr, fr;
    meas_done = 1'b0;
    distancia_cm = '0;
    forever begin
      @(posedge clk); #1;
      if (meas_start) begin
        n_start++;
        if (samp_q.size() > 0) s = samp_q.pop_front();
        else begin s.done = 1'b1; s.dly = 5; s.d = 50; end
        to = !s.done || s.dly > TMO;
        nr = !to && s.d != 0 && s.d < NEAR;
        fr = to || s.d == 0 || s.d >= FAR;
        if (!m_pres) begin
          m_nr = nr ? m_nr + 1 : 0;
          if (m_nr == CONF) begin
            m_pres = 1'b1; m_nr = 0;
            m_cnt = (m_cnt == CMAX) ? 0 : m_cnt + 1;
            lcd_q.push_back(m_cnt);
          end
        end else begin
          m_fr = fr ? m_fr + 1 : 0;
          if (m_fr == CONF) begin m_pres = 1'b0; m_fr = 0; end
        end
        if (to && m_err < 255) m_err++;
        e.pres = m_pres; e.cnt = m_cnt; e.err = m_err;
        exp_q.push_back(e);
        if (s.done) begin
          repeat (s.dly) @(posedge clk);
          #1;
          meas_done = 1'b1; distancia_cm = 16'(s.d); last_done = cyc;
          @(posedge clk); #1;
          meas_done = 1'b0; distancia_cm = '0;
        end
      end
    end
  end

  // Result monitor: each sample's outcome is settled well before start+50.
  initial begin : sb_mon
    exp_t e;
    int   last_st = -1;
    bit   en_lo = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!enable) en_lo = 1'b1;
      if (meas_start) begin
        if (last_st >= 0 && !en_lo) check("start_gap", cyc - last_st, PER);
        last_st = cyc;
        en_lo = 1'b0;
        for (int i = 0; i < 50; i++) begin @(posedge clk); #1; if (!enable) en_lo = 1'b1; end
        if (exp_q.size() == 0) fail_now("scoreboard_empty");
        else begin
          e = exp_q.pop_front();
          check("present",   int'(present),   int'(e.pres));
          check("count",     int'(count),     e.cnt);
          check("count_bcd", int'(count_bcd), (e.cnt / 10) * 16 + (e.cnt % 10));
          check("err_cnt",   int'(err_cnt),   e.err);
        end
      end
    end
  end

  // LCD side: ack 4 cycles after req, check count, latency and req release.
  initial begin : lcd_mon
    bit prev = 1'b0;
    int e;
    lcd_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (lcd_req && !prev) begin
        check("lcd_req_latency", cyc - last_done, 3);
        if (lcd_q.size() == 0) fail_now("unexpected_lcd_req");
        else begin e = lcd_q.pop_front(); check("lcd_count", int'(count), e); end
        repeat (4) @(posedge clk);
        #1;
        check("lcd_req_held", int'(lcd_req), 1);
        lcd_ack = 1'b1;
        @(posedge clk); #1;
        check("lcd_req_drop", int'(lcd_req), 0);
        lcd_ack = 1'b0;
      end
      prev = lcd_req;
    end
  end

  initial begin : stim
    int ns;
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    repeat (3) push(50);                           // idle far traffic
    repeat (3) push(5);                            // confirm -> count 1
    repeat (3) push(12);                           // in band: stays present
    push(20); push(20); push(12); push(20); push(20); push(20);
    repeat (3) push(5);                            // count 2
    push(15); push(14); push(15); push(15); push(0);  // 0 cm is far
    push(9); push(10); push(9); push(9); push(9);  // 10 cm breaks the run; count 3
    push(50, 40);                                  // done on the timeout cycle wins
    push(5, 41);                                   // late done ignored -> timeout
    push(0, 0, 1'b0);
    for (int g = 0; g < 97; g++) begin             // walks count through 99 -> 0
      repeat (3) push(5);
      repeat (3) push(0, 0, 1'b0);
    end
    repeat (7) push(0, 0, 1'b0);
    repeat (3) push(5);                            // last one: enable drops in WAIT

    @(posedge clk); #1;
    enable = 1'b1;
    wait_samp(70000);
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b0;
    wait_exp(200);
    ns = n_start;
    repeat (300) @(posedge clk);
    #1;
    check("no_start_after_disable", n_start, ns);

    push(5);
    enable = 1'b1;
    wait_samp(300);
    repeat (60) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("hold_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/measure_scheduler.md
Name: measure_scheduler

Overview:
- Sequences the ultrasonic ranging datapath.
- Issues periodic measurement starts and waits for each result with a timeout.
- Applies confirmation plus near/far hysteresis to decide object presence.
- Maintains the object count (binary and BCD) and hands each new count to the LCD controller over a req/ack handshake.
- Sits between the ultrasonic controller and the LCD1602 controller in the top level, replacing ad-hoc threshold counting.

Parameters:
- PERIOD_CYCLES, 3_000_000: clocks between successive meas_start pulses (60 ms at 50 MHz).
- TIMEOUT_CYCLES, 1_500_000: max clocks to wait for meas_done. Constraint: TIMEOUT_CYCLES < PERIOD_CYCLES-2.
- NEAR_CM, 10: a distance below this (and nonzero) is a "near" sample.
- FAR_CM, 15: a distance at or above this is a "far" sample. Constraint: FAR_CM >= NEAR_CM.
- CONFIRM_N, 3: consecutive qualifying samples required to change presence. Range 1..15.
- COUNT_MAX, 99: count wraps to 0 after this value. Constraint: COUNT_MAX <= 99.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- enable, input, 1: run measurements while high.
- meas_start, output, 1: one-cycle pulse that starts a ranging cycle.
- meas_done, input, 1: one-cycle pulse; distancia_cm is valid in the same cycle.
- distancia_cm, input, 16: measured distance in cm.
- present, output, 1: confirmed object presence.
- count, output, 7: binary object count.
- count_bcd, output, 8: [7:4] tens, [3:0] units of count.
- lcd_req, output, 1: count update request to the LCD path.
- lcd_ack, input, 1: level acknowledge from the LCD path.
- err_cnt, output, 8: saturating count of measurement timeouts.

Behaviour:
- Reset: state IDLE; all outputs 0; run counters, timers and the pending flag cleared.
- State IDLE:
  - If enable=1, go to START next cycle and clear the period timer.
  - Otherwise stay in IDLE.
- State START:
  - meas_start=1 for exactly this cycle.
  - Wait timer cleared; go to WAIT.
  - The period timer counts every cycle from START.
- State WAIT:
  - meas_done=1: capture distancia_cm, go to EVAL.
  - Wait timer reaches TIMEOUT_CYCLES-1 with no done: err_cnt+1 (saturates at 255), sample treated as far, go to EVAL.
  - meas_done and timeout in the same cycle: done wins, no error counted.
  - meas_done in any other state is ignored.
- State EVAL (1 cycle): sample classification.
  - near: 0 < d < NEAR_CM.
  - far: d >= FAR_CM, or d == 0, or timeout.
  - Between NEAR_CM and FAR_CM: neither.
- EVAL with present=0:
  - near: near_run+1.
  - Otherwise: near_run=0.
  - When near_run reaches CONFIRM_N:
    - present<=1, near_run<=0.
    - count<=count+1, wrapping COUNT_MAX -> 0.
    - count_bcd updated in the same cycle.
    - pending<=1.
- EVAL with present=1:
  - far: far_run+1.
  - Otherwise: far_run=0.
  - When far_run reaches CONFIRM_N: present<=0, far_run<=0. Count unchanged.
- After EVAL: go to HOLD.
- State HOLD:
  - When the period timer reaches PERIOD_CYCLES-1: go to START if enable=1, else IDLE.
  - meas_start pulses are therefore exactly PERIOD_CYCLES apart while enable stays high.
- enable low mid-cycle:
  - The current WAIT/EVAL/HOLD sequence completes; then IDLE.
  - count, present, err_cnt and run counters retained.
- LCD handshake:
  - lcd_req rises the cycle after pending=1, provided lcd_req=0 and lcd_ack=0.
  - lcd_req stays high until lcd_ack is sampled high, then drops the next cycle.
  - pending clears when lcd_req rises.
  - Increments while lcd_req=1 set pending again; they are merged. The LCD reads the live count at ack.
  - A new req only after lcd_ack returns low.
- Latency: near sample confirming presence -> count updated 1 cycle after EVAL entry; lcd_req high 1 cycle later.
- Widths:
  - Run counters are 4 bits.
  - The period timer is sized to hold PERIOD_CYCLES-1.
  - Distance compares are 16-bit unsigned.

Test Plan:
Bench parameters: PERIOD_CYCLES=100, TIMEOUT_CYCLES=40, CONFIRM_N=3, NEAR_CM=10, FAR_CM=15.
- enable=1, meas_done 5 cycles after each start with d=50 -> meas_start every 100 cycles; count=0, present=0, lcd_req never asserted.
- Samples 5,5,5 -> present=1 after the 3rd EVAL, count=1, count_bcd=8'h01, lcd_req high the next cycle; ack after 4 cycles -> lcd_req low the cycle after ack is sampled.
- Hysteresis, starting from present=1:
  - Samples 12,12,12 -> present stays 1.
  - Samples 20,20,12,20,20,20 -> present=0 only after the last sample.
  - Samples 5,5,5 again -> count=2.
- No meas_done -> err_cnt increments every period. Repeat for 300 timeouts -> err_cnt saturates at 255; timeouts act as far samples.
- Count preset to 99 via 99 confirmations, then one more confirmation -> count=0, count_bcd=8'h00.
- Mid-operation cases:
  - enable dropped during WAIT -> done at d=5 still evaluated, then IDLE, no further meas_start.
  - rst asserted during HOLD -> all outputs 0 immediately.
